decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 166 ++++++++++++++++
 tb/tb_decode_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Instruction decode stage: register file with write-first bypass, control decode,
// branch/jump resolution towards fetch, load-use stall and sticky halt.
module decode_stage #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int N_REGS  = 32
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_pc_next,
    input  logic [31:0]        i_instruction,
    input  logic               i_halt,
    input  logic               i_wb_reg_write,
    input  logic [NB_REG-1:0]  i_wb_addr,
    input  logic [NB_DATA-1:0] i_wb_data,
    input  logic               i_ex_mem_read,
    input  logic [NB_REG-1:0]  i_ex_rt,
    output logic               o_stall,
    output logic               o_pc_src,
    output logic [NB_DATA-1:0] o_pc_salto,
    output logic               o_valid,
    output logic               o_halt,
    output logic [NB_DATA-1:0] o_pc_next,
    output logic [NB_DATA-1:0] o_rs_data,
    output logic [NB_DATA-1:0] o_rt_data,
    output logic [NB_DATA-1:0] o_imm,
    output logic [NB_REG-1:0]  o_rs,
    output logic [NB_REG-1:0]  o_rt,
    output logic [NB_REG-1:0]  o_rd,
    output logic [4:0]         o_shamt,
    output logic [5:0]         o_funct,
    output logic               o_reg_write,
    output logic               o_mem_read,
    output logic               o_mem_write,
    output logic               o_mem_to_reg,
    output logic               o_alu_src,
    output logic               o_reg_dst,
    output logic               o_link
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    logic [NB_DATA-1:0] regs [N_REGS];

    logic [5:0]         opcode;
    logic [NB_REG-1:0]  rs, rt, rd;
    logic [15:0]        imm16;
    logic [NB_DATA-1:0] rs_data, rt_data, imm_sext, imm_ext;
    logic [NB_DATA-1:0] branch_target, jump_target;
    logic               c_reg_write, c_mem_read, c_mem_write, c_mem_to_reg;
    logic               c_alu_src, c_reg_dst, c_link, c_zext;
    logic               is_beq, is_bne, is_jump, is_halt_op;
    logic               accept, load;

    assign opcode = i_instruction[31:26];
    assign rs     = NB_REG'(i_instruction[25:21]);
    assign rt     = NB_REG'(i_instruction[20:16]);
    assign rd     = NB_REG'(i_instruction[15:11]);
    assign imm16  = i_instruction[15:0];

    // Write-first bypass: a writeback landing this edge is visible to the read now.
    always_comb begin
        rs_data = '0;
        rt_data = '0;
        if (rs != '0)
            rs_data = (i_wb_reg_write && i_wb_addr == rs) ? i_wb_data : regs[rs];
        if (rt != '0)
            rt_data = (i_wb_reg_write && i_wb_addr == rt) ? i_wb_data : regs[rt];
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
        end else if (i_wb_reg_write && i_wb_addr != '0) begin
            regs[i_wb_addr] <= i_wb_data;
        end
    end

    always_comb begin
        c_reg_write  = 1'b0;
        c_mem_read   = 1'b0;
        c_mem_write  = 1'b0;
        c_mem_to_reg = 1'b0;
        c_alu_src    = 1'b0;
        c_reg_dst    = 1'b0;
        c_link       = 1'b0;
        c_zext       = 1'b0;
        is_beq       = 1'b0;
        is_bne       = 1'b0;
        is_jump      = 1'b0;
        is_halt_op   = 1'b0;
        case (opcode)
            OP_RTYPE: begin c_reg_write = 1'b1; c_reg_dst = 1'b1; end
            OP_ADDI, OP_SLTI, OP_LUI: begin c_reg_write = 1'b1; c_alu_src = 1'b1; end
            OP_ANDI, OP_ORI, OP_XORI: begin
                c_reg_write = 1'b1;
                c_alu_src   = 1'b1;
                c_zext      = 1'b1;
            end
            OP_LW: begin
                c_reg_write  = 1'b1;
                c_mem_read   = 1'b1;
                c_mem_to_reg = 1'b1;
                c_alu_src    = 1'b1;
            end
            OP_SW:   begin c_mem_write = 1'b1; c_alu_src = 1'b1; end
            OP_BEQ:  is_beq = 1'b1;
            OP_BNE:  is_bne = 1'b1;
            OP_J:    is_jump = 1'b1;
            OP_JAL:  begin is_jump = 1'b1; c_reg_write = 1'b1; c_link = 1'b1; end
            OP_HALT: is_halt_op = 1'b1;
            default: ;
        endcase
    end

    assign imm_sext      = {{(NB_DATA-16){imm16[15]}}, imm16};
    assign imm_ext       = c_zext ? {{(NB_DATA-16){1'b0}}, imm16} : imm_sext;
    assign branch_target = i_pc_next + (imm_sext << 2);
    assign jump_target   = {i_pc_next[NB_DATA-1:28], i_instruction[25:0], 2'b00};

    assign o_stall = i_valid && !o_halt && i_ex_mem_read && (i_ex_rt != '0)
                     && (i_ex_rt == rs || i_ex_rt == rt);
    assign accept  = i_valid && !o_stall && !o_halt;
    assign load    = accept && !i_reset;

    assign o_pc_src   = accept && ((is_beq && rs_data == rt_data)
                                   || (is_bne && rs_data != rt_data) || is_jump);
    assign o_pc_salto = is_jump ? jump_target : branch_target;

    // Anything not accepted (stall, invalid, halted, reset) loads an all-zero bubble.
    always_ff @(posedge i_clock) begin
        o_valid      <= load;
        o_halt       <= !i_reset && (o_halt || (accept && (is_halt_op || i_halt)));
        o_pc_next    <= load ? i_pc_next : '0;
        o_rs_data    <= load ? rs_data   : '0;
        o_rt_data    <= load ? rt_data   : '0;
        o_imm        <= load ? imm_ext   : '0;
        o_rs         <= load ? rs        : '0;
        o_rt         <= load ? rt        : '0;
        o_rd         <= load ? (c_link ? NB_REG'(31) : rd) : '0;
        o_shamt      <= load ? i_instruction[10:6] : '0;
        o_funct      <= load ? i_instruction[5:0]  : '0;
        o_reg_write  <= load && c_reg_write;
        o_mem_read   <= load && c_mem_read;
        o_mem_write  <= load && c_mem_write;
        o_mem_to_reg <= load && c_mem_to_reg;
        o_alu_src    <= load && c_alu_src;
        o_reg_dst    <= load && c_reg_dst;
        o_link       <= load && c_link;
    end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: driver predicts from an instruction-level model,
// monitor compares registered outputs after each edge.
module tb_decode_stage;

    logic        i_clock = 1'b0;
    logic        i_reset, i_valid, i_halt, i_wb_reg_write, i_ex_mem_read;
    logic [31:0] i_pc_next, i_instruction, i_wb_data;
    logic [4:0]  i_wb_addr, i_ex_rt;
    logic        o_stall, o_pc_src, o_valid, o_halt;
    logic [31:0] o_pc_salto, o_pc_next, o_rs_data, o_rt_data, o_imm;
    logic [4:0]  o_rs, o_rt, o_rd, o_shamt;
    logic [5:0]  o_funct;
    logic        o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_alu_src, o_reg_dst, o_link;

    always #5 i_clock = ~i_clock;

    decode_stage dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .i_pc_next(i_pc_next),
        .i_instruction(i_instruction), .i_halt(i_halt), .i_wb_reg_write(i_wb_reg_write),
        .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .i_ex_mem_read(i_ex_mem_read),
        .i_ex_rt(i_ex_rt), .o_stall(o_stall), .o_pc_src(o_pc_src), .o_pc_salto(o_pc_salto),
        .o_valid(o_valid), .o_halt(o_halt), .o_pc_next(o_pc_next), .o_rs_data(o_rs_data),
        .o_rt_data(o_rt_data), .o_imm(o_imm), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd),
        .o_shamt(o_shamt), .o_funct(o_funct), .o_reg_write(o_reg_write),
        .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_mem_to_reg(o_mem_to_reg),
        .o_alu_src(o_alu_src), .o_reg_dst(o_reg_dst), .o_link(o_link)
    );

    typedef struct packed {
        logic        valid;
        logic        halt;
        logic [6:0]  ctl;   // reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, link
        logic [31:0] pc_next, rs_data, rt_data, imm;
        logic [4:0]  rs, rt, rd, shamt;
        logic [5:0]  funct;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] rf[32];
    logic        m_halt;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_reg(input logic [4:0] a, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
        if (a == 0) return 32'h0;
        if (we && wa == a) return wd;
        return rf[a];
    endfunction

    function automatic exp_t decode(input logic [31:0] ins, input logic [31:0] pc,
                                    input logic [31:0] rsd, input logic [31:0] rtd);
        exp_t       e = '0;
        logic [5:0] op = ins[31:26];
        logic rw = 0, mr = 0, mw = 0, m2r = 0, as = 0, rdst = 0, lk = 0;
        case (op)
            6'h00: begin rw = 1; rdst = 1; end
            6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin rw = 1; as = 1; end
            6'h23: begin rw = 1; mr = 1; m2r = 1; as = 1; end
            6'h2B: begin mw = 1; as = 1; end
            6'h03: begin rw = 1; lk = 1; end
            default: ;
        endcase
        e.valid   = 1'b1;
        e.ctl     = {rw, mr, mw, m2r, as, rdst, lk};
        e.pc_next = pc;
        e.rs_data = rsd;
        e.rt_data = rtd;
        e.imm     = (op inside {6'h0C, 6'h0D, 6'h0E}) ? {16'h0, ins[15:0]}
                                                      : {{16{ins[15]}}, ins[15:0]};
        e.rs      = ins[25:21];
        e.rt      = ins[20:16];
        e.rd      = (op == 6'h03) ? 5'd31 : ins[15:11];
        e.shamt   = ins[10:6];
        e.funct   = ins[5:0];
        return e;
    endfunction

    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic ih, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic mr, input logic [4:0] ert,
                        input logic rst);
        logic [31:0] rsd, rtd, tgt;
        logic [5:0]  op;
        logic        stall_e, acc, take;
        exp_t        e;
        @(negedge i_clock);
        i_valid = v; i_pc_next = pc; i_instruction = ins; i_halt = ih;
        i_wb_reg_write = we; i_wb_addr = wa; i_wb_data = wd;
        i_ex_mem_read = mr; i_ex_rt = ert; i_reset = rst;
        #1;
        op  = ins[31:26];
        rsd = rd_reg(ins[25:21], we, wa, wd);
        rtd = rd_reg(ins[20:16], we, wa, wd);
        stall_e = v && !m_halt && mr && ert != 0 && (ert == ins[25:21] || ert == ins[20:16]);
        check("stall", 200'(o_stall), 200'(stall_e));
        acc  = v && !stall_e && !m_halt;
        take = (op == 6'h04 && rsd == rtd) || (op == 6'h05 && rsd != rtd)
               || op == 6'h02 || op == 6'h03;
        check("pc_src", 200'(o_pc_src), 200'(acc && take));
        if (op inside {6'h02, 6'h03})
            tgt = {pc[31:28], ins[25:0], 2'b00};
        else
            tgt = pc + 32'(int'($signed(ins[15:0])) * 4);
        if (op inside {6'h02, 6'h03, 6'h04, 6'h05})
            check("pc_salto", 200'(o_pc_salto), 200'(tgt));
        e = (acc && !rst) ? decode(ins, pc, rsd, rtd) : '0;
        e.halt = !rst && (m_halt || (acc && (op == 6'h3F || ih)));
        sb.push_back(e);
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        end else if (we && wa != 0) begin
            rf[wa] = wd;
        end
        m_halt = e.halt;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge i_clock);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("o_valid", 200'(o_valid), 200'(e.valid));
                check("o_halt", 200'(o_halt), 200'(e.halt));
                check("ctl", 200'({o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg,
                                   o_alu_src, o_reg_dst, o_link}), 200'(e.ctl));
                if (e.valid)
                    check("data", 200'({o_pc_next, o_rs_data, o_rt_data, o_imm, o_rs, o_rt,
                                        o_rd, o_shamt, o_funct}),
                          200'({e.pc_next, e.rs_data, e.rt_data, e.imm, e.rs, e.rt,
                                e.rd, e.shamt, e.funct}));
            end
        end
    end

    function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                          input logic [4:0] d, input logic [5:0] fn);
        return {6'h00, s, t, d, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0] pool [15] = '{6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23,
                                  6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h01, 6'h20};
        logic [31:0] w = $urandom;
        w[31:26] = pool[$urandom_range(0, 14)];
        w[25:21] = 5'($urandom_range(0, 7));
        w[20:16] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    initial begin : driver
        logic [31:0] ins;
        m_halt = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        i_reset = 1; i_valid = 0; i_pc_next = 0; i_instruction = 0; i_halt = 0;
        i_wb_reg_write = 0; i_wb_addr = 0; i_wb_data = 0; i_ex_mem_read = 0; i_ex_rt = 0;

        step(1, 32'h4, 32'h20A6FFFF, 0, 1, 5'd9, 32'h55, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // ADDI with sign-extended -1 after WB of r5
        step(0, 0, 0, 0, 1, 5'd5, 32'h10, 0, 0, 0);
        step(1, 32'h8, 32'h20A6FFFF, 0, 0, 0, 0, 0, 0, 0);
        // same-cycle bypass, then write to r0 ignored
        step(1, 32'hC, rtype(5'd3, 5'd0, 5'd4, 6'h25), 0, 1, 5'd3, 32'hDEADBEEF, 0, 0, 0);
        step(1, 32'h10, rtype(5'd0, 5'd0, 5'd1, 6'h21), 0, 1, 5'd0, 32'h1234, 0, 0, 0);
        step(1, 32'h14, rtype(5'd0, 5'd3, 5'd1, 6'h21), 0, 0, 0, 0, 0, 0, 0);
        // load-use stall then release
        step(1, 32'h18, rtype(5'd7, 5'd2, 5'd8, 6'h21), 0, 0, 0, 0, 1, 5'd7, 0);
        step(1, 32'h18, rtype(5'd7, 5'd2, 5'd8, 6'h21), 0, 0, 0, 0, 0, 5'd7, 0);
        // branch taken / not taken
        step(0, 0, 0, 0, 1, 5'd1, 32'd9, 0, 0, 0);
        step(0, 0, 0, 0, 1, 5'd2, 32'd9, 0, 0, 0);
        step(1, 32'h100, itype(6'h04, 5'd1, 5'd2, 16'd4), 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 5'd2, 32'd8, 0, 0, 0);
        step(1, 32'h100, itype(6'h04, 5'd1, 5'd2, 16'd4), 0, 0, 0, 0, 0, 0, 0);
        step(1, 32'h100, itype(6'h05, 5'd1, 5'd2, 16'hFFFC), 0, 0, 0, 0, 0, 0, 0);
        step(1, 32'h10000004, {6'h03, 26'h000040}, 0, 0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 600; n++) begin
            ins = rand_instr();
            step(($urandom_range(0, 9) < 8), $urandom, ins, 0, $urandom_range(0, 1),
                 5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 3) == 0),
                 5'($urandom_range(0, 7)), ($urandom_range(0, 99) == 0));
        end

        // HALT opcode: sticky across further valid instructions, cleared by reset
        step(1, 32'h200, {6'h3F, 26'h0}, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 10; n++)
            step(1, $urandom, rand_instr(), 0, 1, 5'($urandom_range(1, 7)), $urandom,
                 1, 5'($urandom_range(0, 7)), 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 32'h300, itype(6'h08, 5'd0, 5'd2, 16'h8001), 0, 0, 0, 0, 0, 0, 0);
        // fetch-side halt
        step(1, 32'h304, itype(6'h0D, 5'd0, 5'd2, 16'h8001), 1, 0, 0, 0, 0, 0, 0);
        step(1, 32'h308, itype(6'h08, 5'd0, 5'd2, 16'h1), 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        @(negedge i_clock);
        check("sb_drained", 200'(sb.size()), 200'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
